// File: rtl/manycore_barrier_ctrl_if.sv
// Barrier request/grant bundle between the core array and the barrier controller.
// Latency: none, wires only.
// Backpressure: none; requests are level signals held by the cores until the grant arrives.
interface manycore_barrier_ctrl_if #(
    parameter int NUM_CORES = 64,
    parameter int TIMEOUT_W = 20,
    parameter int EPOCH_W   = 16
);
    logic [NUM_CORES-1:0] i_core_req;
    logic [NUM_CORES-1:0] i_core_mask;
    logic                 i_sync_to_frame;
    logic                 i_frame_tick;
    logic [TIMEOUT_W-1:0] i_timeout_limit;
    logic                 i_clear_timeout;
    logic                 o_core_grant;
    logic [1:0]           o_state;
    logic [EPOCH_W-1:0]   o_epoch;
    logic                 o_timeout;
    logic [NUM_CORES-1:0] o_missing_core;

    // Core-array / config side: drives requests and configuration, observes grant and status.
    modport master (
        output i_core_req, i_core_mask, i_sync_to_frame, i_frame_tick,
               i_timeout_limit, i_clear_timeout,
        input  o_core_grant, o_state, o_epoch, o_timeout, o_missing_core
    );

    // Controller side.
    modport slave (
        input  i_core_req, i_core_mask, i_sync_to_frame, i_frame_tick,
               i_timeout_limit, i_clear_timeout,
        output o_core_grant, o_state, o_epoch, o_timeout, o_missing_core
    );
endinterface

// File: rtl/manycore_barrier_ctrl.sv
// Barrier scheduler: gathers per-core requests, raises a shared grant, counts epochs, flags stuck cores.
// Latency: grant rises 1 cycle after the last arrival (or after the frame tick) and falls 1 cycle after the last withdrawal.
// Backpressure: none; cores hold their level request until the grant arrives, then drop it.
module manycore_barrier_ctrl #(
    parameter int NUM_CORES = 64,
    parameter int TIMEOUT_W = 20,
    parameter int EPOCH_W   = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    manycore_barrier_ctrl_if.slave   bus
);
    typedef enum logic [1:0] {
        GATHER     = 2'd0,
        WAIT_FRAME = 2'd1,
        RELEASE    = 2'd2
    } state_t;

    state_t               state;
    state_t               state_nxt;
    logic                 grant;
    logic                 grant_nxt;
    logic [EPOCH_W-1:0]   epoch;
    logic [TIMEOUT_W-1:0] timer;
    logic                 timeout;
    logic [NUM_CORES-1:0] missing;

    logic                 all_set;
    logic                 all_clr;
    logic                 any_en;
    logic                 any_req;
    logic                 timer_run;
    logic                 timeout_hit;
    logic                 epoch_inc;
    logic [TIMEOUT_W-1:0] limit_m1;
    logic [NUM_CORES-1:0] snapshot;

    // Arrival/withdrawal terms on live inputs; masked-off cores never block and never count.
    always_comb begin
        all_set   = &(bus.i_core_req | ~bus.i_core_mask);
        all_clr   = ~|(bus.i_core_req & bus.i_core_mask);
        any_en    = |bus.i_core_mask;
        any_req   = ~all_clr;
        limit_m1  = bus.i_timeout_limit - TIMEOUT_W'(1);
        // Timer only advances while someone is actually stalled: a partial gather, or an unfinished release.
        timer_run = ((state == GATHER) && any_req) || (state == RELEASE);
        // Gated with timer_run so an idle gather or a frame wait (timer parked at 0) never trips a limit of 1.
        timeout_hit = (bus.i_timeout_limit != '0) && timer_run && (timer == limit_m1);
        snapshot  = (state == RELEASE) ? (bus.i_core_mask & bus.i_core_req)
                                       : (bus.i_core_mask & ~bus.i_core_req);
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state <= GATHER;
        else       state <= state_nxt;
    end

    // Next-state: a tick coinciding with the gather->wait transition is ignored because GATHER never looks at it.
    always_comb begin
        state_nxt = state;
        case (state)
            GATHER:     if (any_en && all_set)
                            state_nxt = bus.i_sync_to_frame ? WAIT_FRAME : RELEASE;
            WAIT_FRAME: if (bus.i_frame_tick) state_nxt = RELEASE;
            RELEASE:    if (all_clr) state_nxt = GATHER;
            default:    state_nxt = GATHER;
        endcase
    end

    // Outputs derived from the FSM: grant is registered from the next state, epoch bumps on release exit.
    always_comb begin
        grant_nxt   = (state_nxt == RELEASE);
        epoch_inc   = (state == RELEASE) && all_clr;
        bus.o_state = state;
    end

    // Grant and epoch registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            grant <= 1'b0;
            epoch <= '0;
        end else begin
            grant <= grant_nxt;
            if (epoch_inc) epoch <= epoch + EPOCH_W'(1);
        end
    end

    // Phase timer: restarts on every state change, frozen while waiting for a frame, saturates.
    always_ff @(posedge clk) begin
        if (reset)                  timer <= '0;
        else if (state_nxt != state) timer <= '0;
        else if (timer_run && (timer != '1)) timer <= timer + TIMEOUT_W'(1);
    end

    // Sticky timeout with one snapshot per event; a new event beats a simultaneous clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            timeout <= 1'b0;
            missing <= '0;
        end else if (timeout_hit && (!timeout || bus.i_clear_timeout)) begin
            timeout <= 1'b1;
            missing <= snapshot;
        end else if (bus.i_clear_timeout) begin
            timeout <= 1'b0;
            missing <= '0;
        end
    end

    assign bus.o_core_grant   = grant;
    assign bus.o_epoch        = epoch;
    assign bus.o_timeout      = timeout;
    assign bus.o_missing_core = missing;
endmodule
